// File: rtl/mips_cpu_div_unit.sv
// mips_cpu_div_unit
//   Iterative restoring divider serving DIV (signed) and DIVU (unsigned).
//   One quotient bit is resolved per clock, so a normal division occupies
//   WIDTH iteration cycles plus one sign-fix cycle and one done cycle.
//
// Ports
//   clk      system clock, all state changes on the rising edge
//   reset    synchronous active-high reset, dominates start
//   start    division request, only honoured while idle
//   signdiv  1 = signed division, 0 = unsigned; captured with start
//   a, b     dividend and divisor; captured with start
//   q, r     quotient and remainder, registered and held between operations
//   busy     high while an accepted operation is in progress (through done)
//   divdone  single-cycle pulse, q/r are valid from this cycle on
//   divzero  set together with divdone when the divisor was zero

module mips_cpu_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signdiv,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             divdone,
  output logic             divzero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  state_t           state;
  state_t           next_state;

  logic             sgn_mode;
  logic             sign_a;
  logic             sign_b;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] bmag;
  logic [CW-1:0]    count;

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             ge;

  // One restoring step: the partial remainder is shifted left with the next
  // dividend bit, which needs one extra bit so a divisor with its MSB set
  // still compares correctly. When the compare succeeds the difference is
  // guaranteed to fit back in WIDTH bits, so the low bits of the subtraction
  // are all that is kept.
  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    ge      = (shifted >= {1'b0, bmag});
    diff    = shifted[WIDTH-1:0] - bmag;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and handshake outputs. busy covers every non-idle state,
  // which makes it high from the cycle after acceptance up to and including
  // the done cycle. A start seen in DONE is deliberately not taken; the
  // requester keeps it asserted into the following IDLE cycle.
  always_comb begin
    next_state = state;
    busy       = (state != IDLE);
    divdone    = (state == DONE);
    case (state)
      IDLE: begin
        if (start) begin
          next_state = (b == '0) ? DONE : CALC;
        end
      end
      CALC: begin
        if (count == CW'(1)) begin
          next_state = FIX;
        end
      end
      FIX:     next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath. The dividend magnitude is loaded into the quotient register
  // and shifted out MSB-first while quotient bits shift in at the LSB.
  // Result registers are only touched when an operation completes (FIX, or
  // the divide-by-zero shortcut) so they hold steady otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      sgn_mode <= 1'b0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      rem      <= '0;
      quo      <= '0;
      bmag     <= '0;
      count    <= '0;
      q        <= '0;
      r        <= '0;
      divzero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sgn_mode <= signdiv;
            sign_a   <= a[WIDTH-1];
            sign_b   <= b[WIDTH-1];
            quo      <= (signdiv && a[WIDTH-1]) ? (~a + 1'b1) : a;
            bmag     <= (signdiv && b[WIDTH-1]) ? (~b + 1'b1) : b;
            rem      <= '0;
            count    <= CW'(WIDTH);
            // A zero divisor skips iteration and publishes its result now.
            if (b == '0) begin
              q       <= '0;
              r       <= a;
              divzero <= 1'b1;
            end
          end
        end
        CALC: begin
          rem   <= ge ? diff : shifted[WIDTH-1:0];
          quo   <= {quo[WIDTH-2:0], ge};
          count <= count - CW'(1);
        end
        FIX: begin
          // Quotient is negative when operand signs differ; the remainder
          // follows the dividend's sign. The most-negative / -1 case needs
          // no special handling: its unnegated magnitude is already the
          // wrapped result.
          q       <= (sgn_mode && (sign_a ^ sign_b)) ? (~quo + 1'b1) : quo;
          r       <= (sgn_mode && sign_a) ? (~rem + 1'b1) : rem;
          divzero <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
